updown_mod_counter: RTL and testbench

Parametrised synchronous up/down modulo-N counter with enable, synchronous clear, parallel load, terminal-count flag and wrap pulse. It supersedes the fixed 2-bit ripple counter as the step/iteration counter for the sequential multiplier datapath and for any control FSM that needs a programmable loop count. All state changes on one clock edge; no derived clocks.

---
 rtl/counter_pkg.sv | 14 +
 rtl/updown_mod_counter_next.sv | 67 ++++++
 rtl/updown_mod_counter.sv | 58 +++++
 tb/tb_updown_mod_counter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared counter definitions: direction encodings and the load clamp used by
// the datapath's programmable counters.
package counter_pkg;

   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;

   // Out-of-range load values clamp to the top of the count range.
   function automatic logic [32:0] clamp_load(input logic [32:0] val,
                                              input logic [32:0] modulus);
      clamp_load = (val < modulus) ? val : (modulus - 33'd1);
   endfunction

endpackage

// File: rtl/updown_mod_counter_next.sv
// Combinational next-count and wrap-event calculation for updown_mod_counter.
// UPDOWN_MOD_COUNTER_SATURATE_EN selects saturation instead of wrap-around.
module updown_mod_counter_next
   import counter_pkg::*;
#(
   parameter int          WIDTH   = 4,
   parameter longint      MODULUS = 10
) (
   input  logic [WIDTH-1:0] i_count,
   input  logic             i_en,
   input  logic             i_up,
   input  logic             i_sclr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_next,
   output logic             o_wrap
);

   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_W = MOD_W - 1'b1;

   logic [WIDTH:0] w_cnt_ext;
   logic [WIDTH:0] w_load_ext;
   logic [WIDTH:0] w_next_ext;
   logic           w_wrap;

   assign w_cnt_ext  = {1'b0, i_count};
   assign w_load_ext = (WIDTH+1)'(clamp_load(33'(i_load_val), 33'(MODULUS)));

   always_comb begin
      w_next_ext = w_cnt_ext;
      w_wrap     = 1'b0;
      if (i_sclr) begin
         w_next_ext = '0;
      end else if (i_load) begin
         w_next_ext = w_load_ext;
      end else if (i_en) begin
         if (i_up == CNT_UP) begin
            if (w_cnt_ext == MAX_W) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
               w_next_ext = MAX_W;
`else
               w_next_ext = '0;
               w_wrap     = 1'b1;
`endif
            end else begin
               w_next_ext = w_cnt_ext + 1'b1;
            end
         end else begin
            if (w_cnt_ext == '0) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
               w_next_ext = '0;
`else
               w_next_ext = MAX_W;
               w_wrap     = 1'b1;
`endif
            end else begin
               w_next_ext = w_cnt_ext - 1'b1;
            end
         end
      end
   end

   assign o_next = WIDTH'(w_next_ext);
   assign o_wrap = w_wrap;

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-N counter: count register, wrap pulse flop and tc decode.
// Define UPDOWN_MOD_COUNTER_SATURATE_EN for saturating instead of wrapping.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int          WIDTH   = 4,
   parameter longint      MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS) - 1'b1;

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap;

   updown_mod_counter_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .i_count    (r_count),
      .i_en       (en),
      .i_up       (up),
      .i_sclr     (sclr),
      .i_load     (load),
      .i_load_val (load_val),
      .o_next     (w_next),
      .o_wrap     (w_wrap)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_next;
         r_wrap  <= w_wrap;
      end
   end

   // Terminal count looks at the live direction, not the enable.
   assign tc    = ((up == CNT_UP) && ({1'b0, r_count} == MAX_W)) ||
                  ((up == CNT_DN) && (r_count == '0));
   assign count = r_count;
   assign wrap  = r_wrap;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter (WIDTH=4/MODULUS=10 plus a MODULUS=2
// instance for back-to-back wraps); expectations follow the build macro.
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0, up = 1'b0, sclr = 1'b0, load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] count;
   logic       tc, wrap;

   logic       en2 = 1'b0, up2 = 1'b0;
   logic [0:0] load_val2 = '0;
   logic [0:0] count2;
   logic       tc2, wrap2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk(clk), .reset(reset), .en(en), .up(up), .sclr(sclr), .load(load),
      .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
   );

   updown_mod_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
      .clk(clk), .reset(reset), .en(en2), .up(up2), .sclr(1'b0), .load(1'b0),
      .load_val(load_val2), .count(count2), .tc(tc2), .wrap(wrap2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset();
      #12;
      up = 1'b0;
      #1;
      chk("reset_count", count, 4'd0);
      chk("reset_wrap", {3'b0, wrap}, 4'd0);
      chk("reset_tc_dn", {3'b0, tc}, 4'd1);
      up = 1'b1;
      #1;
      chk("reset_tc_up", {3'b0, tc}, 4'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_count_up();
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
      logic [3:0] exp_c[12] = '{1,2,3,4,5,6,7,8,9,9,9,9};
      logic       exp_w[12] = '{0,0,0,0,0,0,0,0,0,0,0,0};
`else
      logic [3:0] exp_c[12] = '{1,2,3,4,5,6,7,8,9,0,1,2};
      logic       exp_w[12] = '{0,0,0,0,0,0,0,0,0,1,0,0};
`endif
      up = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk($sformatf("up_count[%0d]", i), count, exp_c[i]);
         chk($sformatf("up_wrap[%0d]", i), {3'b0, wrap}, {3'b0, exp_w[i]});
         chk($sformatf("up_tc[%0d]", i), {3'b0, tc}, (exp_c[i] == 4'd9) ? 4'd1 : 4'd0);
      end
      en = 1'b0;
      sclr = 1'b1;
      step();
      sclr = 1'b0;
      chk("sclr_count", count, 4'd0);
      chk("sclr_wrap", {3'b0, wrap}, 4'd0);
   endtask

   task automatic test_count_down();
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
      logic [3:0] exp_c[3] = '{0,0,0};
      logic       exp_w[3] = '{0,0,0};
`else
      logic [3:0] exp_c[3] = '{9,8,7};
      logic       exp_w[3] = '{1,0,0};
`endif
      up = 1'b0;
      #1;
      chk("dn_tc_at0", {3'b0, tc}, 4'd1);
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("dn_count[%0d]", i), count, exp_c[i]);
         chk($sformatf("dn_wrap[%0d]", i), {3'b0, wrap}, {3'b0, exp_w[i]});
      end
      en = 1'b0;
      step();
      chk("hold_count", count, exp_c[2]);
      chk("hold_wrap", {3'b0, wrap}, 4'd0);
   endtask

   task automatic test_load();
      load = 1'b1;
      load_val = 4'd13;
      step();
      chk("load_clamp", count, 4'd9);
      load_val = 4'd5;
      en = 1'b1;
      up = 1'b1;
      step();
      chk("load_beats_en", count, 4'd5);
      sclr = 1'b1;
      step();
      chk("sclr_beats_load", count, 4'd0);
      sclr = 1'b0;
      load_val = 4'd10;
      step();
      chk("load_clamp_10", count, 4'd9);
      load = 1'b0;
      en = 1'b0;
   endtask

   task automatic test_wrap_suppress();
      load = 1'b1;
      load_val = 4'd9;
      step();
      load = 1'b0;
      up = 1'b1;
      en = 1'b1;
      sclr = 1'b1;
      step();
      chk("sclr_wrap_count", count, 4'd0);
      chk("sclr_wrap_flag", {3'b0, wrap}, 4'd0);
      sclr = 1'b0;
      en = 1'b0;
      load = 1'b1;
      step();
      en = 1'b1;
      load_val = 4'd4;
      step();
      chk("load_wrap_count", count, 4'd4);
      chk("load_wrap_flag", {3'b0, wrap}, 4'd0);
      load = 1'b0;
      en = 1'b0;
   endtask

   task automatic test_back_to_back();
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
      logic [3:0] exp_c[4] = '{1,1,1,1};
      logic       exp_w[4] = '{0,0,0,0};
`else
      logic [3:0] exp_c[4] = '{1,0,1,0};
      logic       exp_w[4] = '{0,1,0,1};
`endif
      up2 = 1'b1;
      en2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("m2_count[%0d]", i), {3'b0, count2}, exp_c[i]);
         chk($sformatf("m2_wrap[%0d]", i), {3'b0, wrap2}, {3'b0, exp_w[i]});
      end
      en2 = 1'b0;
   endtask

   task automatic test_async_reset();
      load = 1'b1;
      load_val = 4'd6;
      step();
      load = 1'b0;
      chk("pre_reset_count", count, 4'd6);
      up = 1'b1;
      en = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_count", count, 4'd0);
      chk("async_reset_wrap", {3'b0, wrap}, 4'd0);
      reset = 1'b1;
      step();
      chk("resume_count", count, 4'd1);
      // Abort a wrap pulse that is already showing.
      en = 1'b0;
      load = 1'b1;
      load_val = 4'd9;
      step();
      load = 1'b0;
      en = 1'b1;
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("abort_wrap_flag", {3'b0, wrap}, 4'd0);
      chk("abort_wrap_count", count, 4'd0);
      en = 1'b0;
      reset = 1'b1;
      step();
      chk("post_abort_wrap", {3'b0, wrap}, 4'd0);
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_wrap_suppress();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
